// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Field-slice positions follow the LAMBA instruction format (opcode high, funct low).
package fetch_unit_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_HOLD  = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetch response that lands while ID is stalled.
// Load/drain/clear take effect on the next edge; drain and clear both empty it, and win over load.
module if_skid_buffer
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                drain,
    input  logic                clear,
    input  logic [31:0]         load_instr,
    input  logic [PC_WIDTH-1:0] load_pc_plus1,
    output logic                full,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc_plus1
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full     <= 1'b0;
            instr    <= INSTR_NOP;
            pc_plus1 <= '0;
        end else if (drain || clear) begin
            full <= 1'b0;
        end else if (load) begin
            full     <= 1'b1;
            instr    <= load_instr;
            pc_plus1 <= load_pc_plus1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, variable-latency imem req/ack, skid buffer and IF/ID register; 1 cycle ack-to-opcode.
// Stall freezes IF/ID and parks a late response in the skid; redirects flush and override stall.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                     PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                jump_valid,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch_valid,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [31:0]         if_id_instr,
    output logic [PC_WIDTH-1:0] if_id_pc_plus1,
    output logic                if_id_valid,
    output logic [5:0]          opcode,
    output logic [5:0]          funct
);

    if_state_e           state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt, pc_inc;
    logic [PC_WIDTH-1:0] drain_addr, drain_addr_nxt;
    logic [31:0]         instr_nxt;
    logic [PC_WIDTH-1:0] pc_plus1_nxt;
    logic                valid_nxt;

    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_target;

    logic                skid_load, skid_drain, skid_clear, skid_full;
    logic [31:0]         skid_instr;
    logic [PC_WIDTH-1:0] skid_pc_plus1;

    assign redirect        = branch_valid || jump_valid;
    assign redirect_target = branch_valid ? branch_target : jump_target;
    assign pc_inc          = pc + PC_WIDTH'(1);

    // The skid is full exactly while parked in HOLD, so it doubles as the request gate.
    assign imem_req  = rst_n && !skid_full;
    assign imem_addr = (state == IF_DRAIN) ? drain_addr : pc;

    assign opcode = if_id_instr[OPCODE_MSB:OPCODE_LSB];
    assign funct  = if_id_instr[FUNCT_MSB:FUNCT_LSB];

    if_skid_buffer #(
        .PC_WIDTH (PC_WIDTH)
    ) u_skid (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (skid_load),
        .drain         (skid_drain),
        .clear         (skid_clear),
        .load_instr    (imem_rdata),
        .load_pc_plus1 (pc_inc),
        .full          (skid_full),
        .instr         (skid_instr),
        .pc_plus1      (skid_pc_plus1)
    );

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        instr_nxt      = if_id_instr;
        pc_plus1_nxt   = if_id_pc_plus1;
        valid_nxt      = if_id_valid;
        skid_load      = 1'b0;
        skid_drain     = 1'b0;
        skid_clear     = 1'b0;

        case (state)
            IF_FETCH: begin
                if (redirect) begin
                    pc_nxt     = redirect_target;
                    valid_nxt  = 1'b0;
                    instr_nxt  = INSTR_NOP;
                    skid_clear = 1'b1;
                    // A request still in flight must complete before the new PC goes out.
                    if (!imem_ack) begin
                        state_nxt      = IF_DRAIN;
                        drain_addr_nxt = pc;
                    end
                end else if (imem_ack && !stall) begin
                    valid_nxt    = 1'b1;
                    instr_nxt    = imem_rdata;
                    pc_plus1_nxt = pc_inc;
                    pc_nxt       = pc_inc;
                end else if (imem_ack) begin
                    skid_load = 1'b1;
                    pc_nxt    = pc_inc;
                    state_nxt = IF_HOLD;
                end else if (!stall) begin
                    valid_nxt = 1'b0;
                    instr_nxt = INSTR_NOP;
                end
            end
            IF_HOLD: begin
                if (redirect) begin
                    pc_nxt     = redirect_target;
                    valid_nxt  = 1'b0;
                    instr_nxt  = INSTR_NOP;
                    skid_clear = 1'b1;
                    state_nxt  = IF_FETCH;
                end else if (!stall) begin
                    valid_nxt    = 1'b1;
                    instr_nxt    = skid_instr;
                    pc_plus1_nxt = skid_pc_plus1;
                    skid_drain   = 1'b1;
                    state_nxt    = IF_FETCH;
                end
            end
            IF_DRAIN: begin
                if (redirect) begin
                    pc_nxt    = redirect_target;
                    valid_nxt = 1'b0;
                    instr_nxt = INSTR_NOP;
                end
                if (imem_ack) begin
                    state_nxt = IF_FETCH;
                end
            end
            default: begin
                state_nxt = IF_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IF_FETCH;
            pc             <= RESET_PC;
            drain_addr     <= RESET_PC;
            if_id_valid    <= 1'b0;
            if_id_instr    <= INSTR_NOP;
            if_id_pc_plus1 <= '0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            drain_addr     <= drain_addr_nxt;
            if_id_valid    <= valid_nxt;
            if_id_instr    <= instr_nxt;
            if_id_pc_plus1 <= pc_plus1_nxt;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the LAPI DOpaCA LAMBA core; generates the opcode/funct stream that the decode control logic consumes, and acts on the is_jump/is_branch redirects that decode produces.
- Holds the PC and drives a variable-latency instruction-memory req/ack handshake.
- A one-entry skid buffer absorbs a response that arrives while the pipeline is stalled.
- Owns the IF/ID register and presents opcode, funct, pc+1 and valid to the ID stage.

Parameters:
- PC_WIDTH, 16, width of the word-addressed PC and of every target/address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  PC_WIDTH  word address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  single-cycle response strobe; may rise in the same cycle as the request.
- imem_rdata  in  32  instruction; valid only when imem_ack=1.
- stall  in  1  hazard stall; IF/ID holds.
- jump_valid  in  1  ID-stage redirect (is_jump).
- jump_target  in  PC_WIDTH  jump target.
- branch_valid  in  1  MEM-stage taken branch.
- branch_target  in  PC_WIDTH  branch target.
- if_id_instr  out  32  registered instruction.
- if_id_pc_plus1  out  PC_WIDTH  registered pc+1 of that instruction; used for the JAL write-back.
- if_id_valid  out  1  IF/ID holds a real instruction.
- opcode  out  6  equals if_id_instr[31:26].
- funct  out  6  equals if_id_instr[5:0].

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc=RESET_PC; state=FETCH.
  - skid empty; imem_req=0 during the reset cycle.
  - if_id_valid=0, if_id_instr=`INSTR_NOP, if_id_pc_plus1=0.
  - An outstanding memory request is abandoned; memory is required to be reset in the same cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Ack with stall=0 and no redirect: IF/ID<=(rdata, pc+1, valid=1); pc<=pc+1. Next address is issued the following cycle, giving a throughput of 1 instruction per cycle with a zero-wait memory.
  - No ack with stall=0: IF/ID<=bubble (valid=0, `INSTR_NOP).
  - Ack with stall=1: skid<=(rdata, pc+1); pc<=pc+1; go to HOLD. IF/ID is unchanged.
  - No ack with stall=1: IF/ID is unchanged; the request stays pending.
- HOLD:
  - imem_req=0; skid is full.
  - When stall falls: IF/ID<=skid, skid cleared, go to FETCH.
- DRAIN:
  - Entered when a redirect hits while a request is pending (imem_req=1, no ack).
  - imem_req stays 1 with the old address until ack; the ack data is discarded.
  - Then go to FETCH at the already-updated pc.
- Redirect rules (priority branch_valid > jump_valid > stall):
  - pc<=target; if_id_valid<=0 and IF/ID<=`INSTR_NOP; skid cleared.
  - From FETCH with ack in the same cycle: data discarded, stay in FETCH.
  - From FETCH without ack: go to DRAIN.
  - From HOLD: go to FETCH.
  - In DRAIN: a new redirect overwrites pc; stay in DRAIN.
  - A redirect overrides a simultaneous stall.
- Arithmetic: pc+1 wraps modulo 2^PC_WIDTH; at pc all-ones, pc+1 = 0.
- opcode/funct are combinational slices of if_id_instr. They read 0 during a bubble because `INSTR_NOP=32'h0.
- Latency: instruction at address A, with ack in cycle t, is visible on opcode in cycle t+1.

Decomposition:
- lapido_defs.v gets:
  - `INSTR_NOP (32'h0000_0000).
  - Field-slice macros `OPCODE_MSB/LSB (31/26) and `FUNCT_MSB/LSB (5/0).
  - FSM encodings `IF_FETCH, `IF_HOLD, `IF_DRAIN.
- One natural sub-module: if_skid_buffer (one-entry register plus full flag, with load/drain/clear).
- The FSM and IF/ID register stay in fetch_unit.

Test Plan:
- Reset release, zero-wait memory returning mem[a]=32'h1000_000a → imem_addr steps 0,1,2,3 on consecutive cycles. opcode=6'h04 from cycle 2; if_id_pc_plus1 goes 1,2,3.
- Memory acks every 3rd cycle, stall=0 → if_id_valid pattern 1,0,0 repeats; pc only advances on an ack.
- stall=1 asserted in an ack cycle at pc=5, held 4 cycles → IF/ID keeps instr@4; skid holds instr@5 and imem_req=0. After release, IF/ID gets instr@5 and the fetch of 6 follows.
- jump_valid=1, jump_target=16'h0040 while a request to 7 is pending; the ack arrives 2 cycles later → the ack data is dropped with if_id_valid=0, and the next imem_addr is 16'h0040.
- branch_valid (target 16'h0100) and jump_valid (target 16'h0200) in the same cycle, with stall=1 → the next imem_addr is 16'h0100; IF/ID is flushed despite the stall.
- pc=16'hFFFF fetched with an ack → if_id_pc_plus1=0 and the next imem_addr=0. rst_n=0 during DRAIN → state returns to FETCH at RESET_PC with all outputs at their reset values.
